// File: rtl/packet_buffer_tx_streamer.sv
// Drains packets from the slot-based packet buffer read port and emits them
// as a valid/ready word stream with byte-keep and last flags.
// Ports:
//   clk_i, reset_i (async, active-high)
//   packet_avail_i / packet_ack_o       : slot occupancy and release pulse
//   packet_rvalid_o / packet_raddr_o    : word read request (byte address)
//   packet_rdata_i                      : read data, one cycle after request
//   packet_rsize_i                      : packet size in bytes
//   tx_valid_o / tx_ready_i             : stream handshake
//   tx_data_o / tx_keep_o / tx_last_o   : stream word, byte mask, end flag
module packet_buffer_tx_streamer #(
    parameter int data_width_p = 64,
    parameter int els_p = 2048,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int packet_size_width_lp = $clog2(els_p + 1),
    localparam int keep_width_lp = data_width_p / 8
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            packet_avail_i,
    output logic                            packet_ack_o,
    output logic                            packet_rvalid_o,
    output logic [addr_width_lp-1:0]        packet_raddr_o,
    input  logic [data_width_p-1:0]         packet_rdata_i,
    input  logic [packet_size_width_lp-1:0] packet_rsize_i,
    output logic                            tx_valid_o,
    input  logic                            tx_ready_i,
    output logic [data_width_p-1:0]         tx_data_o,
    output logic [keep_width_lp-1:0]        tx_keep_o,
    output logic                            tx_last_o
);

    localparam int sw_lp = packet_size_width_lp;
    localparam int kw_lp = keep_width_lp;
    localparam int ks_lp = $clog2(keep_width_lp);

    typedef enum logic [1:0] {IDLE, STREAM, ACK} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [sw_lp-1:0] r_words;
    logic [sw_lp-1:0] r_issued;
    logic [ks_lp-1:0] r_rem;

    logic [sw_lp-1:0] w_size_clamped;
    logic [sw_lp:0]   w_round;
    logic [sw_lp-1:0] w_words_calc;
    logic [kw_lp-1:0] w_one_sh;
    logic [kw_lp-1:0] w_tail_keep;
    logic             w_is_last_word;
    logic             w_issue;
    logic             w_pop;
    logic [2:0]       w_occ;
    logic             w_credit_ok;

    // Tag of the read currently in flight; it joins the data on return.
    logic             r_inflight;
    logic [kw_lp-1:0] r_inf_keep;
    logic             r_inf_last;

    logic [data_width_p-1:0] r_fifo_data [2];
    logic [kw_lp-1:0]        r_fifo_keep [2];
    logic [1:0]              r_fifo_last;
    logic                    r_wptr;
    logic                    r_rptr;
    logic [1:0]              r_count;

    assign w_size_clamped = (packet_rsize_i > sw_lp'(els_p))
                          ? sw_lp'(els_p) : packet_rsize_i;
    // Extra bit keeps the round-up from overflowing near els_p.
    assign w_round = {1'b0, w_size_clamped} + (sw_lp + 1)'(kw_lp - 1);
    assign w_words_calc = sw_lp'(w_round >> ks_lp);

    assign w_one_sh = {{(kw_lp - 1){1'b0}}, 1'b1} << r_rem;
    assign w_tail_keep = (r_rem == '0) ? '1 : w_one_sh - 1'b1;

    assign w_is_last_word = (r_issued == r_words - 1'b1);
    assign w_pop = (r_count != 2'd0) & tx_ready_i;

    // Words buffered or in flight once this cycle's pop retires.
    assign w_occ = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_credit_ok = (w_occ - {2'b00, w_pop}) < 3'd2;

    assign w_issue = (r_state == STREAM) && (r_issued < r_words)
                   && w_credit_ok;

    assign packet_rvalid_o = w_issue;
    assign packet_raddr_o = {r_issued[addr_width_lp-ks_lp-1:0],
                             {ks_lp{1'b0}}};

    always_comb begin
        w_state_nxt = r_state;
        packet_ack_o = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (packet_avail_i) begin
                    w_state_nxt = (w_size_clamped == '0) ? ACK : STREAM;
                end
            end
            STREAM: begin
                if (w_issue && w_is_last_word) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                packet_ack_o = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_words    <= '0;
            r_issued   <= '0;
            r_rem      <= '0;
            r_inflight <= 1'b0;
            r_inf_keep <= '0;
            r_inf_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && packet_avail_i) begin
                r_words  <= w_words_calc;
                r_issued <= '0;
                r_rem    <= w_size_clamped[ks_lp-1:0];
            end else if (w_issue) begin
                r_issued <= r_issued + 1'b1;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inf_keep <= w_is_last_word ? w_tail_keep : '1;
                r_inf_last <= w_is_last_word;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_fifo_keep <= '{default: '0};
            r_fifo_last <= 2'b00;
        end else begin
            if (r_inflight) begin
                r_fifo_keep[r_wptr] <= r_inf_keep;
                r_fifo_last[r_wptr] <= r_inf_last;
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // Payload needs no reset; it is masked by tx_valid_o.
    always_ff @(posedge clk_i) begin
        if (r_inflight) begin
            r_fifo_data[r_wptr] <= packet_rdata_i;
        end
    end

    assign tx_valid_o = (r_count != 2'd0);
    assign tx_data_o  = r_fifo_data[r_rptr];
    assign tx_keep_o  = tx_valid_o ? r_fifo_keep[r_rptr] : '0;
    assign tx_last_o  = tx_valid_o & r_fifo_last[r_rptr];

    a_avail_held: assert property (
        @(posedge clk_i) disable iff (reset_i)
        (r_state == STREAM) |-> packet_avail_i
    ) else $error("packet_avail_i dropped while streaming");

endmodule

// File: tb/tb_packet_buffer_tx_streamer.sv
// Scoreboard bench for packet_buffer_tx_streamer (64-bit and 32-bit builds).
// Buffer bytes are seed + byte address, so every beat is predictable.
module tb_packet_buffer_tx_streamer;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat64_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat32_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 64-bit DUT signals and buffer model
    logic        av64, ack64, rv64, tv64, rdy64, tl64;
    logic [10:0] raddr64;
    logic [63:0] rdata64 = '0;
    logic [63:0] td64;
    logic [11:0] rsize64;
    logic [7:0]  tk64;
    int          sz64_a [16];
    logic [7:0]  sd64_a [16];
    int          nload64 = 0;
    int          head64 = 0;
    beat64_t     q64[$];

    // 32-bit DUT signals and buffer model
    logic        av32, ack32, rv32, tv32, tl32;
    logic        rdy32 = 1'b1;
    logic [10:0] raddr32;
    logic [31:0] rdata32 = '0;
    logic [31:0] td32;
    logic [11:0] rsize32;
    logic [3:0]  tk32;
    int          sz32_a [16];
    logic [7:0]  sd32_a [16];
    int          nload32 = 0;
    int          head32 = 0;
    beat32_t     q32[$];

    packet_buffer_tx_streamer #(.data_width_p(64), .els_p(2048)) u_dut64 (
        .clk_i(clk), .reset_i(rst),
        .packet_avail_i(av64), .packet_ack_o(ack64),
        .packet_rvalid_o(rv64), .packet_raddr_o(raddr64),
        .packet_rdata_i(rdata64), .packet_rsize_i(rsize64),
        .tx_valid_o(tv64), .tx_ready_i(rdy64),
        .tx_data_o(td64), .tx_keep_o(tk64), .tx_last_o(tl64)
    );

    packet_buffer_tx_streamer #(.data_width_p(32), .els_p(2048)) u_dut32 (
        .clk_i(clk), .reset_i(rst),
        .packet_avail_i(av32), .packet_ack_o(ack32),
        .packet_rvalid_o(rv32), .packet_raddr_o(raddr32),
        .packet_rdata_i(rdata32), .packet_rsize_i(rsize32),
        .tx_valid_o(tv32), .tx_ready_i(rdy32),
        .tx_data_o(td32), .tx_keep_o(tk32), .tx_last_o(tl32)
    );

    function automatic logic [63:0] mkw64(logic [7:0] s, logic [10:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = s + a[7:0] + 8'(i);
        return w;
    endfunction

    function automatic logic [31:0] mkw32(logic [7:0] s, logic [10:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = s + a[7:0] + 8'(i);
        return w;
    endfunction

    function automatic logic [63:0] mask64(logic [7:0] k);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    function automatic logic [31:0] mask32(logic [3:0] k);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    assign av64    = (head64 != nload64);
    assign rsize64 = 12'(sz64_a[head64[3:0]]);
    assign av32    = (head32 != nload32);
    assign rsize32 = 12'(sz32_a[head32[3:0]]);

    always @(posedge clk) begin
        if (ack64) head64 <= head64 + 1;
        if (ack32) head32 <= head32 + 1;
        if (rv64) rdata64 <= mkw64(sd64_a[head64[3:0]], raddr64);
        if (rv32) rdata32 <= mkw32(sd32_a[head32[3:0]], raddr32);
    end

    // Monitor state for the 64-bit stream
    int          rd_idx64 = 0;
    int          tot_rd64 = 0;
    int          tot_pop64 = 0;
    int          npop64 = 0;
    int          nack64 = 0;
    int          last_rd_cyc64 = -10;
    logic [10:0] last_raddr64 = '0;
    logic        prev_stall64 = 1'b0;
    beat64_t     prev_b64;
    int          rd0_cyc64 [16];
    int          ack_cyc64 [16];
    logic [7:0]  lastkeep64 = '0;
    int          nack32 = 0;
    logic [3:0]  lastkeep32 = '0;

    always @(negedge clk) begin
        int      sz;
        int      words;
        beat64_t e;
        if (rst) begin
            rd_idx64 = 0;
            tot_rd64 = 0;
            tot_pop64 = 0;
            prev_stall64 = 1'b0;
        end else begin
            sz = sz64_a[head64[3:0]];
            if (sz > 2048) sz = 2048;
            words = (sz + 7) / 8;
            if (prev_stall64) begin
                chk("stall_valid", 64'(tv64), 64'd1);
                chk("stall_data", td64, prev_b64.d);
                chk("stall_keep", 64'(tk64), 64'(prev_b64.k));
                chk("stall_last", 64'(tl64), 64'(prev_b64.l));
            end
            if (rv64) begin
                chk("raddr", 64'(raddr64), 64'(rd_idx64 * 8));
                chk("rd_in_range", 64'(rd_idx64 < words), 64'd1);
                chk("outstanding",
                    64'((tot_rd64 + 1 - tot_pop64 - int'(tv64 & rdy64)) <= 2),
                    64'd1);
                if (rd_idx64 == 0) rd0_cyc64[head64[3:0]] = cyc;
                rd_idx64++;
                tot_rd64++;
                last_rd_cyc64 = cyc;
                last_raddr64 = raddr64;
            end
            if (tv64 && rdy64) begin
                if (q64.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none",
                             td64);
                end else begin
                    e = q64.pop_front();
                    chk("beat_data", td64 & mask64(e.k), e.d & mask64(e.k));
                    chk("beat_keep", 64'(tk64), 64'(e.k));
                    chk("beat_last", 64'(tl64), 64'(e.l));
                end
                if (tl64) lastkeep64 = tk64;
                tot_pop64++;
                npop64++;
            end
            prev_stall64 = tv64 & ~rdy64;
            prev_b64 = '{d: td64, k: tk64, l: tl64};
            if (ack64) begin
                nack64++;
                if (words != 0) begin
                    chk("ack_after_last_read",
                        64'((last_rd_cyc64 == cyc - 1) &&
                            (int'(last_raddr64) == (words - 1) * 8)), 64'd1);
                end
                ack_cyc64[head64[3:0]] = cyc;
                rd_idx64 = 0;
            end
        end
    end

    always @(negedge clk) begin
        beat32_t e;
        if (!rst) begin
            if (tv32 && rdy32) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat32 actual=%0h required=none",
                             td32);
                end else begin
                    e = q32.pop_front();
                    chk("beat32_data", 64'(td32 & mask32(e.k)),
                        64'(e.d & mask32(e.k)));
                    chk("beat32_keep", 64'(tk32), 64'(e.k));
                    chk("beat32_last", 64'(tl32), 64'(e.l));
                end
                if (tl32) lastkeep32 = tk32;
            end
            if (ack32) nack32++;
        end
    end

    task automatic push64(int size, logic [7:0] s);
        int      sz;
        int      w;
        beat64_t b;
        sz = (size > 2048) ? 2048 : size;
        w = (sz + 7) / 8;
        for (int k = 0; k < w; k++) begin
            b.d = mkw64(s, 11'(k * 8));
            b.l = (k == w - 1);
            b.k = (b.l && (sz % 8) != 0) ? 8'((1 << (sz % 8)) - 1) : 8'hFF;
            q64.push_back(b);
        end
    endtask

    task automatic load64(int size, logic [7:0] s);
        push64(size, s);
        sz64_a[nload64[3:0]] = size;
        sd64_a[nload64[3:0]] = s;
        nload64++;
    endtask

    task automatic load32(int size, logic [7:0] s);
        int      w;
        beat32_t b;
        w = (size + 3) / 4;
        for (int k = 0; k < w; k++) begin
            b.d = mkw32(s, 11'(k * 4));
            b.l = (k == w - 1);
            b.k = (b.l && (size % 4) != 0) ? 4'((1 << (size % 4)) - 1) : 4'hF;
            q32.push_back(b);
        end
        sz32_a[nload32[3:0]] = size;
        sd32_a[nload32[3:0]] = s;
        nload32++;
    endtask

    task automatic drain(string nm, int budget);
        int n = 0;
        while ((q64.size() != 0 || q32.size() != 0 || av64 || av32 ||
                tv64 || tv32) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_timeout"}, 64'(n < budget), 64'd1);
        chk({nm, "_q_empty"}, 64'(q64.size() + q32.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rst_checks(string nm);
        chk({nm, "_ack"}, 64'(ack64), 64'd0);
        chk({nm, "_rvalid"}, 64'(rv64), 64'd0);
        chk({nm, "_raddr"}, 64'(raddr64), 64'd0);
        chk({nm, "_tvalid"}, 64'(tv64), 64'd0);
        chk({nm, "_keep"}, 64'(tk64), 64'd0);
        chk({nm, "_last"}, 64'(tl64), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rd0, tv0, tvl, tvcnt, s1, s2, a0, p0;
        rdy64 = 1'b1;
        #1;
        rst_checks("reset");
        chk("reset_tvalid32", 64'(tv32), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: 64 bytes, full throughput
        a0 = nack64;
        c0 = cyc;
        rd0 = -1;
        tv0 = -1;
        tvl = -1;
        tvcnt = 0;
        load64(64, 8'h10);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (rv64 && rd0 < 0) rd0 = cyc;
            if (tv64 && tv0 < 0) tv0 = cyc;
            if (tv64) begin
                tvcnt++;
                tvl = cyc;
            end
        end
        chk("t1_rd_latency", 64'(rd0 - c0), 64'd1);
        chk("t1_tv_latency", 64'(tv0 - rd0), 64'd2);
        chk("t1_beats", 64'(tvcnt), 64'd8);
        chk("t1_consecutive", 64'(tvl - tv0), 64'd7);
        chk("t1_lastkeep", 64'(lastkeep64), 64'hFF);
        drain("t1", 100);
        chk("t1_acks", 64'(nack64 - a0), 64'd1);

        // 2: 13 bytes on both widths
        load64(13, 8'h20);
        load32(13, 8'h30);
        drain("t2", 100);
        chk("t2_lastkeep64", 64'(lastkeep64), 64'h1F);
        chk("t2_lastkeep32", 64'(lastkeep32), 64'h1);
        chk("t2_acks32", 64'(nack32), 64'd1);

        // 3: backpressure window
        load64(64, 8'h40);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            rdy64 = !(k >= 3 && k <= 9);
        end
        rdy64 = 1'b1;
        drain("t3", 100);

        // 4: back-to-back packets
        a0 = nack64;
        s1 = nload64;
        s2 = nload64 + 1;
        load64(16, 8'h50);
        load64(24, 8'h60);
        drain("t4", 100);
        chk("t4_acks", 64'(nack64 - a0), 64'd2);
        chk("t4_gap", 64'(rd0_cyc64[s2[3:0]] - ack_cyc64[s1[3:0]]), 64'd2);

        // 5: empty packet, then clamped oversize packet
        a0 = nack64;
        load64(0, 8'h00);
        @(posedge clk);
        #1;
        chk("t5_zero_ack", 64'(ack64), 64'd1);
        chk("t5_zero_rvalid", 64'(rv64), 64'd0);
        @(posedge clk);
        #1;
        chk("t5_zero_ack_pulse", 64'(ack64), 64'd0);
        chk("t5_zero_tvalid", 64'(tv64), 64'd0);
        p0 = npop64;
        load64(4095, 8'h70);
        drain("t5", 400);
        chk("t5_clamp_beats", 64'(npop64 - p0), 64'd256);
        chk("t5_lastkeep", 64'(lastkeep64), 64'hFF);
        chk("t5_acks", 64'(nack64 - a0), 64'd2);

        // 6: reset after three beats, then restream
        a0 = nack64;
        p0 = npop64;
        load64(64, 8'h80);
        for (int i = 0; i < 30 && npop64 < p0 + 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_three_beats", 64'(npop64 - p0), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        rst_checks("t6_reset");
        q64.delete();
        push64(64, 8'h80);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain("t6", 100);
        chk("t6_acks", 64'(nack64 - a0), 64'd1);
        chk("t6_total_beats", 64'(npop64 - p0), 64'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_buffer_tx_streamer.md
Name: packet_buffer_tx_streamer

Overview:
- Drains completed packets from the read side of the slot-based Ethernet packet buffer and emits each one as a valid/ready word stream with byte-keep and last flags.
- Sits between the packet buffer's read port and the MAC transmit datapath or a DMA sink.
- Owns the buffer read handshake: packet_avail/packet_ack, word reads with 1-cycle synchronous latency, and the size register.
- Converts them into a backpressure-tolerant stream at 1 word/cycle.

Parameters:
- data_width_p, 64, stream/buffer word width in bits; only 32 or 64 are legal.
- els_p, 2048, bytes per buffer slot (maximum packet size).
- addr_width_lp (local), $clog2(els_p), byte address width.
- packet_size_width_lp (local), $clog2(els_p+1), packet size width.
- keep_width_lp (local), data_width_p/8, bytes per word.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- packet_avail_i  in  1  buffer read slot holds a packet.
- packet_ack_o  out  1  one-cycle pulse that frees the read slot.
- packet_rvalid_o  out  1  word read request.
- packet_raddr_o  out  addr_width_lp  word-aligned byte address of the read.
- packet_rdata_i  in  data_width_p  read data, valid the cycle after packet_rvalid_o.
- packet_rsize_i  in  packet_size_width_lp  packet size in bytes; valid while packet_avail_i is high.
- tx_valid_o  out  1  stream word valid.
- tx_ready_i  in  1  downstream accepts the word.
- tx_data_o  out  data_width_p  stream word; byte 0 is in bits [7:0].
- tx_keep_o  out  keep_width_lp  valid-byte mask, contiguous from bit 0.
- tx_last_o  out  1  final word of the packet.

Behaviour:
- Reset: asynchronous and active-high; it clears the FSM, counters and the skid FIFO.
- Output values during and after reset: packet_ack_o=0, packet_rvalid_o=0, packet_raddr_o=0, tx_valid_o=0, tx_keep_o=0, tx_last_o=0. tx_data_o is don't-care while tx_valid_o=0.
- Reset mid-packet: the partial packet is abandoned with no ack. The slot remains in the buffer and is restreamed from byte 0 after reset.
- FSM states are IDLE, STREAM and ACK.
- IDLE:
  - When packet_avail_i=1, latch size = min(packet_rsize_i, els_p).
  - Set words = ceil(size/keep_width_lp), clear the read word index, go to STREAM.
  - If the latched size is 0, go directly to ACK and emit no beats.
- STREAM:
  - packet_rvalid_o = (issued < words) & credit_ok.
  - packet_raddr_o = issued*keep_width_lp, which is always aligned.
  - credit_ok = (fifo_count + inflight - pop_this_cycle) < 2. inflight is 1 if a read was issued in the previous cycle; pop = tx_valid_o & tx_ready_i.
  - The returning word is written into a 2-entry skid FIFO the cycle after its read. Its keep/last tag is computed at issue and travels with the inflight bit.
  - Once the last read has been issued, go to ACK on the next cycle, i.e. the cycle in which that word's data is captured.
- ACK:
  - packet_ack_o=1 for exactly one cycle, then return to IDLE.
  - The ack never waits for downstream drain; the skid FIFO holds the remaining words.
  - IDLE may start the next packet in the cycle after ACK, while the FIFO is still non-empty. Ordering is preserved.
- packet_avail_i dropping while in STREAM is a protocol violation; simulation flags it with an assertion error.
- tx_valid_o = FIFO non-empty, driven directly from FIFO registers (no combinational path from packet_rdata_i).
- tx_keep_o:
  - all ones on non-last words;
  - on the last word, (1<<r)-1 where r = size mod keep_width_lp, or all ones if r=0.
- tx_last_o=1 only on word words-1.
- Latency: first packet_rvalid_o comes 1 cycle after IDLE samples avail. First tx_valid_o comes 2 cycles after the first packet_rvalid_o.
- Throughput: with tx_ready_i held high, 1 word/cycle sustained, plus 2 cycles of overhead (ACK, IDLE) between packets.
- Backpressure: never more than 2 words buffered-or-inflight. Holding tx_ready_i low stalls reads with no loss or duplication.
- The stream holds tx_valid_o and tx_data_o stable until tx_ready_i.

Test Plan:
1. data_width_p=64, size=64, tx_ready_i=1 -> 8 beats on 8 consecutive cycles; keep=0xFF on every beat; tx_last_o on beat 8; raddr 0,8,...,56; one ack pulse 1 cycle after the raddr=56 read.
2. size=13 (64-bit) -> 2 beats, keep 0xFF then 0x1F, last on beat 2. The same test with data_width_p=32 -> 4 beats, final keep 0x1.
3. size=64, tx_ready_i low for cycles 3-9 -> at most 2 reads before the stall; tx_data/keep stable while stalled; all 8 words delivered in order exactly once.
4. Two packets back-to-back (sizes 16 and 24, buffer preloaded with distinct patterns) -> 2 beats then 3 beats; packet 2's first read starts 2 cycles after packet 1's ack; two ack pulses in total.
5. size=0 -> no tx_valid_o and no packet_rvalid_o; ack pulses 1 cycle after avail is sampled. size=4095 -> clamped to els_p=2048 (256 beats).
6. Assert reset_i asynchronously mid-packet (after 3 beats) -> all outputs are 0 immediately, no ack. After release the same packet restreams from raddr=0 and completes.
